// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Melody source for the PWM audio stage. It steps through a 32-entry note ROM
// for the selected track and synthesises a square wave at the note's
// half-period. It emits one unsigned 8-bit sample per SAMPLE_DIV clocks, with a
// one-cycle valid strobe.
//
// Optional feature macro: NOTE_SEQ_ENVELOPE_EN
//   defined   -> the amplitude envelope decays by env>>3 every DECAY_SAMPLES
//                ticks and reloads at each note.
//   undefined -> the envelope is fixed at 0xF0 and no decay counter exists.
//
// Parameters
//   SAMPLE_DIV     clock cycles per sample (>= 2)
//   NOTE_SAMPLES   samples per note step
//   DECAY_SAMPLES  samples between envelope decay steps
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        run (1) / pause (0)
//   audio_select  track select, latched at note boundaries
//   sample        unsigned audio sample, 0x80 = silence
//   sample_valid  one-cycle strobe marking a new sample
//   note_idx      index of the note currently playing
// -----------------------------------------------------------------------------
module note_sequencer #(
  parameter int SAMPLE_DIV    = 256,
  parameter int NOTE_SAMPLES  = 12288,
  parameter int DECAY_SAMPLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] audio_select,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic [4:0] note_idx
);

  localparam int SCNT_W = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
  localparam int NCNT_W = (NOTE_SAMPLES > 1) ? $clog2(NOTE_SAMPLES) : 1;

  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(SAMPLE_DIV - 1);
  localparam logic [NCNT_W-1:0] NCNT_MAX = NCNT_W'(NOTE_SAMPLES - 1);

  localparam logic [7:0] SILENCE  = 8'h80;
  localparam logic [7:0] ENV_INIT = 8'hF0;

  // Half-periods in samples; 0 is a rest.
  localparam logic [7:0] TRACK0 [32] = '{
    8'd93,  8'd0,   8'd93,  8'd83,  8'd74,  8'd0,   8'd62,  8'd74,
    8'd83,  8'd93,  8'd99,  8'd0,   8'd111, 8'd111, 8'd99,  8'd93,
    8'd74,  8'd74,  8'd83,  8'd93,  8'd99,  8'd0,   8'd93,  8'd83,
    8'd74,  8'd70,  8'd62,  8'd0,   8'd62,  8'd74,  8'd93,  8'd0
  };
  localparam logic [7:0] TRACK1 [32] = '{
    8'd124, 8'd124, 8'd111, 8'd0,   8'd99,  8'd99,  8'd93,  8'd0,
    8'd83,  8'd83,  8'd74,  8'd0,   8'd62,  8'd62,  8'd0,   8'd0,
    8'd62,  8'd70,  8'd74,  8'd83,  8'd93,  8'd99,  8'd111, 8'd0,
    8'd124, 8'd0,   8'd124, 8'd0,   8'd111, 8'd99,  8'd124, 8'd0
  };
  localparam logic [7:0] TRACK2 [32] = '{
    8'd148, 8'd0,   8'd124, 8'd0,   8'd148, 8'd0,   8'd124, 8'd0,
    8'd111, 8'd111, 8'd99,  8'd99,  8'd93,  8'd93,  8'd83,  8'd0,
    8'd74,  8'd0,   8'd62,  8'd0,   8'd74,  8'd0,   8'd83,  8'd0,
    8'd93,  8'd93,  8'd99,  8'd99,  8'd111, 8'd0,   8'd148, 8'd0
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t            r_state;
  logic              r_paused_in_load;
  logic [1:0]        r_track;
  logic [4:0]        r_step;
  logic [7:0]        r_hp;
  logic [7:0]        r_hcnt;
  logic              r_phase;
  logic [SCNT_W-1:0] r_scnt;
  logic [NCNT_W-1:0] r_ncnt;
  logic [7:0]        r_sample;
  logic              r_valid;
  logic [4:0]        r_note_idx;

  logic [7:0]        w_rom_hp;
  logic [7:0]        w_env;
  logic [7:0]        w_amp;
  logic [7:0]        w_sample_calc;
  logic              w_tick;
  logic [SCNT_W-1:0] w_scnt_next;

`ifdef NOTE_SEQ_ENVELOPE_EN
  localparam int DCNT_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DECAY_SAMPLES - 1);

  logic [7:0]        r_env;
  logic [DCNT_W-1:0] r_dcnt;

  assign w_env = r_env;
`else
  // Without the envelope the decay interval has no effect.
  logic w_unused_decay;
  assign w_unused_decay = (DECAY_SAMPLES > 0);
  assign w_env = ENV_INIT;
`endif

  // Track 3 is a test ramp: the entry value equals its index.
  always_comb begin
    w_rom_hp = 8'h00;
    case (r_track)
      2'd0:    w_rom_hp = TRACK0[r_step];
      2'd1:    w_rom_hp = TRACK1[r_step];
      2'd2:    w_rom_hp = TRACK2[r_step];
      default: w_rom_hp = {3'b000, r_step};
    endcase
  end

  assign w_tick      = (r_scnt == SCNT_MAX);
  assign w_scnt_next = w_tick ? '0 : r_scnt + 1'b1;

  // env <= 0xF0, so amp <= 0x78 and the sum/difference stays inside 8 bits.
  assign w_amp         = w_env >> 1;
  assign w_sample_calc = (r_hp == 8'h00) ? SILENCE :
                         (r_phase ? SILENCE + w_amp : SILENCE - w_amp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_paused_in_load <= 1'b0;
      r_track          <= 2'd0;
      r_step           <= 5'd0;
      r_hp             <= 8'h00;
      r_hcnt           <= 8'h00;
      r_phase          <= 1'b1;
      r_scnt           <= '0;
      r_ncnt           <= '0;
      r_sample         <= SILENCE;
      r_valid          <= 1'b0;
      r_note_idx       <= 5'd0;
`ifdef NOTE_SEQ_ENVELOPE_EN
      r_env            <= ENV_INIT;
      r_dcnt           <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_scnt <= '0;
          if (enable) begin
            r_track <= audio_select;
            r_step  <= 5'd0;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (!enable) begin
            // The load itself is deferred until playback resumes.
            r_paused_in_load <= 1'b1;
            r_sample         <= SILENCE;
            r_state          <= S_PAUSE;
          end else begin
            r_hp       <= w_rom_hp;
            r_hcnt     <= 8'h00;
            r_phase    <= 1'b1;
            r_ncnt     <= '0;
            r_note_idx <= r_step;
            // The sample counter keeps running so the sample rate does not
            // slip across note boundaries.
            r_scnt     <= w_scnt_next;
`ifdef NOTE_SEQ_ENVELOPE_EN
            r_env      <= ENV_INIT;
            r_dcnt     <= '0;
`endif
            r_state    <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (!enable) begin
            // A tick that coincides with this edge is held back, not issued.
            r_paused_in_load <= 1'b0;
            r_sample         <= SILENCE;
            r_state          <= S_PAUSE;
          end else begin
            r_scnt <= w_scnt_next;
            if (w_tick) begin
              r_sample <= w_sample_calc;
              r_valid  <= 1'b1;

              if (r_hp != 8'h00) begin
                if (r_hcnt == r_hp - 8'd1) begin
                  r_hcnt  <= 8'h00;
                  r_phase <= ~r_phase;
                end else begin
                  r_hcnt <= r_hcnt + 8'd1;
                end
              end

`ifdef NOTE_SEQ_ENVELOPE_EN
              if (r_dcnt == DCNT_MAX) begin
                r_dcnt <= '0;
                r_env  <= r_env - (r_env >> 3);
              end else begin
                r_dcnt <= r_dcnt + 1'b1;
              end
`endif

              if (r_ncnt == NCNT_MAX) begin
                r_ncnt  <= '0;
                r_step  <= r_step + 5'd1;  // 31 wraps to 0
                r_track <= audio_select;
                r_state <= S_LOAD;
              end else begin
                r_ncnt <= r_ncnt + 1'b1;
              end
            end
          end
        end

        S_PAUSE: begin
          r_sample <= SILENCE;
          if (enable) begin
            r_state <= r_paused_in_load ? S_LOAD : S_PLAY;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign note_idx     = r_note_idx;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Bench for note_sequencer with SAMPLE_DIV = 4, NOTE_SAMPLES = 8 and
// DECAY_SAMPLES = 2. Expected samples for each note are pushed to a queue when
// the note is scheduled. They are popped and compared as strobes arrive.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int SDIV   = 4;
  localparam int NSAMP  = 8;
  localparam int DECAY  = 2;
  localparam int BUDGET = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] audio_select;
  logic [7:0] sample;
  logic       sample_valid;
  logic [4:0] note_idx;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_s_q   [$];
  logic [4:0] exp_idx_q [$];

  note_sequencer #(
    .SAMPLE_DIV   (SDIV),
    .NOTE_SAMPLES (NSAMP),
    .DECAY_SAMPLES(DECAY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .audio_select(audio_select),
    .sample      (sample),
    .sample_valid(sample_valid),
    .note_idx    (note_idx)
  );

  always #5 clk = ~clk;

  // Expected output of one note with half-period hp. The phase is high in the
  // even-numbered half-periods. The envelope decays once per DECAY ticks.
  task automatic push_note(input logic [7:0] hp, input logic [4:0] idx);
    logic [7:0] env;
    logic [7:0] amp;
    bit         high;
    for (int i = 0; i < NSAMP; i++) begin
      env = 8'hF0;
`ifdef NOTE_SEQ_ENVELOPE_EN
      for (int j = 0; j < i / DECAY; j++) env = env - (env >> 3);
`endif
      amp = env >> 1;
      if (hp == 8'd0) begin
        exp_s_q.push_back(8'h80);
      end else begin
        high = ((i / int'(hp)) % 2) == 0;
        exp_s_q.push_back(high ? 8'h80 + amp : 8'h80 - amp);
      end
      exp_idx_q.push_back(idx);
    end
  endtask

  // Waits for the next strobe. Samples on the falling edge; gap is the number of
  // falling edges waited.
  task automatic wait_strobe(output logic [7:0] s, output logic [4:0] idx,
                             output int gap, output bit timeout);
    gap = 0;
    timeout = 1'b0;
    do begin
      @(negedge clk);
      gap++;
    end while (!sample_valid && gap < BUDGET);
    timeout = !sample_valid;
    s = sample;
    idx = note_idx;
  endtask

  task automatic test_reset();
    int         bad;
    logic [7:0] bad_s;
    logic       bad_v;
    logic [4:0] bad_i;
    rst_n = 1'b0;
    enable = 1'b0;
    audio_select = 2'd3;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sample, sample_valid, note_idx} !== {8'h80, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_held: sample=%02h valid=%0b idx=%0d, expected 80/0/0",
               sample, sample_valid, note_idx);
    end
    rst_n = 1'b1;
    bad = 0;
    bad_s = 8'h80; bad_v = 1'b0; bad_i = 5'd0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if ({sample, sample_valid, note_idx} !== {8'h80, 1'b0, 5'd0}) begin
        if (bad == 0) begin bad_s = sample; bad_v = sample_valid; bad_i = note_idx; end
        bad++;
      end
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL idle_1000: %0d bad cycles, first sample=%02h valid=%0b idx=%0d, expected 0 bad cycles",
               bad, bad_s, bad_v, bad_i);
    end
    $display("test_reset done");
  endtask

  task automatic test_steps();
    logic [7:0] s, es;
    logic [4:0] idx, ei;
    int gap;
    bit to;
    audio_select = 2'd3;
    enable = 1'b1;
    push_note(8'd0, 5'd0);
    push_note(8'd1, 5'd1);
    push_note(8'd2, 5'd2);
    for (int i = 0; i < 3 * NSAMP; i++) begin
      wait_strobe(s, idx, gap, to);
      es = exp_s_q.pop_front();
      ei = exp_idx_q.pop_front();
      vectors++;
      if (to || s !== es || idx !== ei) begin
        miscompares++;
        $display("FAIL steps[%0d]: sample=%02h idx=%0d timeout=%0b, expected sample=%02h idx=%0d",
                 i, s, idx, to, es, ei);
      end
      vectors++;
      if (gap !== ((i == 0) ? SDIV + 1 : SDIV)) begin
        miscompares++;
        $display("FAIL steps_gap[%0d]: gap=%0d, expected %0d", i, gap, (i == 0) ? SDIV + 1 : SDIV);
      end
      $display("steps    strobe %0d: idx=%0d sample=%02h gap=%0d", i, idx, s, gap);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] s, es;
    logic [4:0] idx, ei;
    int gap;
    bit to;
    for (int k = 3; k < 32; k++) push_note(8'(k), 5'(k));
    push_note(8'd0, 5'd0);
    for (int i = 0; i < 30 * NSAMP; i++) begin
      wait_strobe(s, idx, gap, to);
      es = exp_s_q.pop_front();
      ei = exp_idx_q.pop_front();
      vectors++;
      if (to || s !== es || idx !== ei || gap !== SDIV) begin
        miscompares++;
        $display("FAIL wrap[%0d]: sample=%02h idx=%0d gap=%0d timeout=%0b, expected sample=%02h idx=%0d gap=%0d",
                 i, s, idx, gap, to, es, ei, SDIV);
      end
      $display("wrap     strobe %0d: idx=%0d sample=%02h", i, idx, s);
    end
  endtask

  // The track changes 3 -> 0 during step 5, so step 6 plays track 0 entry 6
  // (half-period 62). The track changes back to 3 during step 6.
  task automatic test_track_change();
    logic [7:0] s, es;
    logic [4:0] idx, ei;
    int gap;
    bit to;
    for (int k = 1; k <= 5; k++) push_note(8'(k), 5'(k));
    push_note(8'd62, 5'd6);
    for (int i = 0; i < 6 * NSAMP; i++) begin
      wait_strobe(s, idx, gap, to);
      es = exp_s_q.pop_front();
      ei = exp_idx_q.pop_front();
      vectors++;
      if (to || s !== es || idx !== ei || gap !== SDIV) begin
        miscompares++;
        $display("FAIL track_change[%0d]: sample=%02h idx=%0d gap=%0d timeout=%0b, expected sample=%02h idx=%0d gap=%0d",
                 i, s, idx, gap, to, es, ei, SDIV);
      end
      $display("track    strobe %0d: idx=%0d sample=%02h sel=%0d", i, idx, s, audio_select);
      if (i == 4 * NSAMP + 2) audio_select = 2'd0;
      if (i == 5 * NSAMP + 2) audio_select = 2'd3;
    end
  endtask

  task automatic test_pause();
    logic [7:0] s, es;
    logic [4:0] idx, ei;
    int gap;
    bit to;
    int bad;
    push_note(8'd7, 5'd7);
    push_note(8'd8, 5'd8);
    for (int i = 0; i < 2 * NSAMP; i++) begin
      wait_strobe(s, idx, gap, to);
      es = exp_s_q.pop_front();
      ei = exp_idx_q.pop_front();
      vectors++;
      if (to || s !== es || idx !== ei || (i != 3 && gap !== SDIV)) begin
        miscompares++;
        $display("FAIL pause[%0d]: sample=%02h idx=%0d gap=%0d timeout=%0b, expected sample=%02h idx=%0d",
                 i, s, idx, gap, to, es, ei);
      end
      $display("pause    strobe %0d: idx=%0d sample=%02h", i, idx, s);
      if (i == 2) begin
        enable = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (sample_valid !== 1'b0 || sample !== 8'h80) bad++;
        end
        vectors++;
        if (bad !== 0) begin
          miscompares++;
          $display("FAIL paused_quiet: %0d cycles with strobe or non-silent sample, expected 0", bad);
        end
        enable = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    int bad;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    vectors++;
    if ({sample, sample_valid, note_idx} !== {8'h80, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL async_reset: sample=%02h valid=%0b idx=%0d before any edge, expected 80/0/0",
               sample, sample_valid, note_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ({sample, sample_valid, note_idx} !== {8'h80, 1'b0, 5'd0}) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: %0d active cycles, expected 0", bad);
    end
    $display("async_reset done");
  endtask

  // Step 1 of track 3. With the envelope enabled the amplitude follows
  // 78, 69, 5C, 50. Otherwise it stays at 78.
  task automatic test_envelope();
    logic [7:0] s, es;
    logic [4:0] idx, ei;
    int gap;
    bit to;
    audio_select = 2'd3;
    enable = 1'b1;
    push_note(8'd0, 5'd0);
    push_note(8'd1, 5'd1);
    for (int i = 0; i < 2 * NSAMP; i++) begin
      wait_strobe(s, idx, gap, to);
      es = exp_s_q.pop_front();
      ei = exp_idx_q.pop_front();
      vectors++;
      if (to || s !== es || idx !== ei || gap !== ((i == 0) ? SDIV + 1 : SDIV)) begin
        miscompares++;
        $display("FAIL envelope[%0d]: sample=%02h idx=%0d gap=%0d timeout=%0b, expected sample=%02h idx=%0d",
                 i, s, idx, gap, to, es, ei);
      end
      $display("envelope strobe %0d: idx=%0d sample=%02h", i, idx, s);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    audio_select = 2'd3;
    test_reset();
    test_steps();
    test_wrap();
    test_track_change();
    test_pause();
    test_async_reset();
    test_envelope();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
